// File: rtl/tetris_input_pkg.sv
// Shared op codes, key bit positions, player ids and repeat-FSM states for the input path.
package tetris_input_pkg;

    typedef enum logic [1:0] {
        OP_ROT   = 2'b00,
        OP_LEFT  = 2'b01,
        OP_RIGHT = 2'b10,
        OP_DROP  = 2'b11
    } op_e;

    localparam int KEY_ROT   = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_DROP  = 3;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_DAS,
        ST_RPT
    } fsm_state_e;

    typedef struct packed {
        logic vld;
        op_e  op;
    } slot_t;

    // Rotate beats left beats right beats drop; vld=0 means nothing held.
    function automatic slot_t prio_key(input logic [3:0] nib);
        slot_t r;
        r.vld = 1'b1;
        r.op  = OP_ROT;
        if (nib[KEY_ROT])        r.op = OP_ROT;
        else if (nib[KEY_LEFT])  r.op = OP_LEFT;
        else if (nib[KEY_RIGHT]) r.op = OP_RIGHT;
        else if (nib[KEY_DROP])  r.op = OP_DROP;
        else                     r.vld = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/key_action_scheduler_if.sv
// Command port from the scheduler to the game engine (valid/ready).
interface key_action_scheduler_if;
    import tetris_input_pkg::*;

    logic    cmd_valid;
    logic    cmd_ready;
    player_e cmd_player;
    op_e     cmd_op;

    modport master (output cmd_valid, output cmd_player, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_player, input cmd_op, output cmd_ready);
endinterface

// File: rtl/key_repeat_fsm.sv
// One player's press / delayed-auto-shift / auto-repeat generator; event_o is a
// same-cycle pulse derived from the registered key nibble and the held state.
module key_repeat_fsm
    import tetris_input_pkg::*;
#(
    parameter int DAS_CYC  = 5_000_000,
    parameter int ARR_CYC  = 1_250_000,
    parameter int DROP_CYC = 750_000,
    parameter int CNT_W    = 23
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [3:0] nibble_i,
    output logic       event_o,
    output op_e        op_o
);
    localparam logic [CNT_W-1:0] DAS_LD  = CNT_W'(DAS_CYC - 1);
    localparam logic [CNT_W-1:0] ARR_LD  = CNT_W'(ARR_CYC - 1);
    localparam logic [CNT_W-1:0] DROP_LD = CNT_W'(DROP_CYC - 1);

    fsm_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    op_e              lat_q;
    logic             arm_q;
    slot_t            act;
    logic             press;
    logic             tick;

    always_comb begin
        act     = prio_key(nibble_i);
        press   = enable_i && arm_q && act.vld && (state_q == ST_IDLE || act.op != lat_q);
        tick    = enable_i && act.vld && !press && (state_q == ST_DAS || state_q == ST_RPT)
                  && (cnt_q == '0);
        event_o = press || tick;
        op_o    = act.op;
    end

    // arm_q blocks a key held through reset from firing until it is released once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lat_q   <= OP_ROT;
            arm_q   <= 1'b0;
        end else begin
            if (nibble_i == 4'd0) arm_q <= 1'b1;
            if (!enable_i || !act.vld) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else if (press) begin
                lat_q <= act.op;
                case (act.op)
                    OP_ROT:            begin state_q <= ST_HOLD; cnt_q <= '0;      end
                    OP_LEFT, OP_RIGHT: begin state_q <= ST_DAS;  cnt_q <= DAS_LD;  end
                    OP_DROP:           begin state_q <= ST_RPT;  cnt_q <= DROP_LD; end
                endcase
            end else if (state_q == ST_DAS || state_q == ST_RPT) begin
                if (cnt_q == '0) begin
                    state_q <= ST_RPT;
                    cnt_q   <= (lat_q == OP_DROP) ? DROP_LD : ARR_LD;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/key_action_scheduler.sv
// Held-key vector to game commands for two players, round-robin onto one valid/ready port.
// Press to cmd_valid is 3 cycles; a stalled command holds its payload, newer events overwrite the 1-deep slot.
module key_action_scheduler
    import tetris_input_pkg::*;
#(
    parameter int DAS_CYC  = 5_000_000,
    parameter int ARR_CYC  = 1_250_000,
    parameter int DROP_CYC = 750_000,
    parameter int CNT_W    = 23
) (
    input  logic                          clk25_i,
    input  logic                          rst_i,
    input  logic [7:0]                    key_state_i,
    input  logic                          enable_i,
    key_action_scheduler_if.master        cmd_if
);
    logic [7:0] key_q;
    logic [1:0] ev;
    op_e        ev_op [2];
    slot_t      slot_q [2];
    slot_t      slot_d [2];
    player_e    rr_q, rr_d;
    logic       vld_q, vld_d;
    player_e    ply_q, ply_d;
    op_e        op_q, op_d;
    logic       load;
    logic       gnt_vld;
    player_e    gnt_ply;
    logic [1:0] gnt_oh;

    key_repeat_fsm #(.DAS_CYC(DAS_CYC), .ARR_CYC(ARR_CYC), .DROP_CYC(DROP_CYC), .CNT_W(CNT_W))
    u_fsm_p1 (
        .clk_i(clk25_i), .rst_i(rst_i), .enable_i(enable_i),
        .nibble_i(key_q[3:0]), .event_o(ev[0]), .op_o(ev_op[0])
    );

    key_repeat_fsm #(.DAS_CYC(DAS_CYC), .ARR_CYC(ARR_CYC), .DROP_CYC(DROP_CYC), .CNT_W(CNT_W))
    u_fsm_p2 (
        .clk_i(clk25_i), .rst_i(rst_i), .enable_i(enable_i),
        .nibble_i(key_q[7:4]), .event_o(ev[1]), .op_o(ev_op[1])
    );

    always_comb begin
        load    = !vld_q || cmd_if.cmd_ready;
        gnt_vld = enable_i && load && (slot_q[0].vld || slot_q[1].vld);
        gnt_ply = (slot_q[0].vld && slot_q[1].vld) ? rr_q : (slot_q[1].vld ? P2 : P1);
        gnt_oh  = {gnt_ply == P2, gnt_ply == P1} & {2{gnt_vld}};

        vld_d = vld_q;
        ply_d = ply_q;
        op_d  = op_q;
        rr_d  = rr_q;
        if (load) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                ply_d = gnt_ply;
                op_d  = (gnt_ply == P2) ? slot_q[1].op : slot_q[0].op;
                rr_d  = (gnt_ply == P1) ? P2 : P1;
            end
        end

        // A fresh event wins over a same-cycle drain so it is never lost.
        for (int p = 0; p < 2; p++) begin
            slot_d[p] = slot_q[p];
            if (!enable_i) begin
                slot_d[p] = '0;
            end else if (ev[p]) begin
                slot_d[p].vld = 1'b1;
                slot_d[p].op  = ev_op[p];
            end else if (gnt_oh[p]) begin
                slot_d[p].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk25_i) begin
        key_q <= key_state_i;
    end

    always_ff @(posedge clk25_i) begin
        if (rst_i) begin
            vld_q     <= 1'b0;
            ply_q     <= P1;
            op_q      <= OP_ROT;
            rr_q      <= P1;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else begin
            vld_q     <= vld_d;
            ply_q     <= ply_d;
            op_q      <= op_d;
            rr_q      <= rr_d;
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
        end
    end

    assign cmd_if.cmd_valid  = vld_q;
    assign cmd_if.cmd_player = ply_q;
    assign cmd_if.cmd_op     = op_q;

endmodule
